mem_load_store_unit: RTL and testbench

- Memory-stage load/store unit of the pipelined MIPS. Sits between the EX/MEM register and the data memory.
- Handles lw/lh/lhu/lb/lbu/sw/sh/sb:
  - generates word-aligned bus requests with byte enables and lane-replicated store data;
  - extracts and extends load data;
  - stalls the pipeline while a variable-latency memory completes the access.
- Misaligned accesses are flagged and never reach memory.

---
 rtl/mem_load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mem_load_store_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_store_unit
// Description : Memory-stage load/store unit. Turns lw/lh/lhu/lb/lbu/sw/sh/sb
//               into word-aligned bus requests with byte enables and
//               replicated store data. Extracts and extends load data, and
//               stalls the pipeline until a variable-latency memory finishes.
//               Misaligned accesses raise a pulse and never reach the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_store_unit #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,       // asynchronous, active-low
    input  logic              ex_valid,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              half,
    input  logic              b,
    input  logic              bunsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       writedata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2
    } state_t;

    localparam logic [1:0] c_sz_byte = 2'd0;
    localparam logic [1:0] c_sz_half = 2'd1;
    localparam logic [1:0] c_sz_word = 2'd2;

    state_t            r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic              r_unsigned;
    logic [31:0]       r_rdata;

    logic              w_op;
    logic [1:0]        w_size;
    logic              w_mis;
    logic              w_accept;
    logic [3:0]        w_be_le;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [1:0]        w_blane;
    logic              w_hsel;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    // Decode the EX/MEM instruction: size (byte beats half beats word) and alignment.
    always_comb begin
        w_op     = ex_valid & (memread | memwrite);
        w_size   = b ? c_sz_byte : (half ? c_sz_half : c_sz_word);
        w_mis    = ((w_size == c_sz_half) & addr[0]) |
                   ((w_size == c_sz_word) & (addr[1:0] != 2'b00));
        w_accept = (r_state == S_IDLE) & w_op & ~w_mis;
    end

    // Byte enables and replicated store data; big-endian just mirrors the lanes.
    always_comb begin
        w_be_le = 4'b1111;
        w_wdata = writedata;
        case (w_size)
            c_sz_byte: begin
                w_be_le = 4'b0001 << addr[1:0];
                w_wdata = {4{writedata[7:0]}};
            end
            c_sz_half: begin
                w_be_le = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{writedata[15:0]}};
            end
            default: begin
                w_be_le = 4'b1111;
                w_wdata = writedata;
            end
        endcase
        w_be = BIG_ENDIAN ? {w_be_le[0], w_be_le[1], w_be_le[2], w_be_le[3]} : w_be_le;
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        w_blane = BIG_ENDIAN ? ~r_lane : r_lane;
        w_hsel  = BIG_ENDIAN ? ~r_lane[1] : r_lane[1];
        w_byte  = mem_rdata[7:0];
        case (w_blane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = w_hsel ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load = mem_rdata;
        case (r_size)
            c_sz_byte: w_load = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            c_sz_half: w_load = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            default:   w_load = mem_rdata;
        endcase
    end

    // Pipeline-facing outputs: stall drops in the completion cycle so EX/MEM advances.
    always_comb begin
        stall       = 1'b0;
        misaligned  = 1'b0;
        rdata_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall      = w_accept;
                misaligned = w_op & w_mis;
            end
            S_REQ: begin
                stall = ~(mem_gnt & r_mem_we);
            end
            S_WAIT_R: begin
                stall       = ~mem_rvalid;
                rdata_valid = mem_rvalid;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
        rdata = rdata_valid ? w_load : r_rdata;
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

    // Access sequencer: latch the request, hold it until granted, then await read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_size      <= c_sz_word;
            r_lane      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_rdata     <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= memwrite;
                        r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                        r_size      <= w_size;
                        r_lane      <= addr[1:0];
                        r_unsigned  <= bunsigned;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_state     <= r_mem_we ? S_IDLE : S_WAIT_R;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_be    <= 4'b0000;
                        r_mem_wdata <= 32'h0;
                    end
                end
                S_WAIT_R: begin
                    if (mem_rvalid) begin
                        r_state <= S_IDLE;
                        r_rdata <= w_load;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_load_store_unit
// Description : Directed self-checking bench for mem_load_store_unit with a
//               load-result scoreboard and a simple handshaking memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, memread, memwrite, half, b, bunsigned;
    logic [31:0] addr, writedata;
    logic        stall, rdata_valid, misaligned, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    mem_load_store_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .memread(memread), .memwrite(memwrite),
        .half(half), .b(b), .bunsigned(bunsigned),
        .addr(addr), .writedata(writedata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .misaligned(misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rdata_valid pulse must match the oldest pending load.
    always @(negedge clk) begin
        if (rdata_valid === 1'b1) begin
            if (sb_q.size() == 0) chk("stray_rdata_valid", {31'b0, rdata_valid}, 32'h0);
            else                  chk("sb_rdata", rdata, sb_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        ex_valid = 0; memread = 0; memwrite = 0; half = 0; b = 0; bunsigned = 0;
        addr = 32'h0; writedata = 32'h0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic h, input logic bb,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd);
        ex_valid = 1; memread = rd; memwrite = wr; half = h; b = bb; bunsigned = uns;
        addr = a; writedata = wd;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic h, input logic bb, input logic uns,
                           input logic [31:0] word, input int gnt_dly, input int rv_dly,
                           input logic [3:0] exp_be, input logic [31:0] exp);
        drive_op(1, 0, h, bb, uns, a, 32'h0);
        sb_q.push_back(exp);
        @(negedge clk);
        chk("ld_idle_stall", stall, 1);
        chk("ld_idle_req", mem_req, 0);
        step();
        for (int g = 0; g <= gnt_dly; g++) begin
            mem_gnt = (g == gnt_dly);
            @(negedge clk);
            chk("ld_req", mem_req, 1);
            chk("ld_we", mem_we, 0);
            chk("ld_addr", mem_addr, {a[31:2], 2'b00});
            chk("ld_be", mem_be, exp_be);
            chk("ld_req_stall", stall, 1);
            step();
        end
        mem_gnt = 0;
        for (int r = 0; r <= rv_dly; r++) begin
            mem_rvalid = (r == rv_dly);
            mem_rdata  = word;
            @(negedge clk);
            if (r < rv_dly) begin
                chk("ld_wait_stall", stall, 1);
                chk("ld_wait_req", mem_req, 0);
                chk("ld_wait_valid", rdata_valid, 0);
            end else begin
                chk("ld_done_stall", stall, 0);
                chk("ld_done_valid", rdata_valid, 1);
            end
            step();
        end
        mem_rvalid = 0;
        mem_rdata  = 32'h0;
        idle_inputs();
        @(negedge clk);
        chk("ld_pulse_end", rdata_valid, 0);
        chk("ld_hold", rdata, exp);
        chk("ld_after_stall", stall, 0);
        step();
    endtask

    task automatic do_store(input logic [31:0] a, input logic h, input logic bb,
                            input logic [31:0] wd, input int gnt_dly,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        drive_op(0, 1, h, bb, 0, a, wd);
        @(negedge clk);
        chk("st_idle_stall", stall, 1);
        chk("st_idle_req", mem_req, 0);
        step();
        writedata = ~wd;  // payload must already be registered
        for (int g = 0; g <= gnt_dly; g++) begin
            mem_gnt = (g == gnt_dly);
            @(negedge clk);
            chk("st_req", mem_req, 1);
            chk("st_we", mem_we, 1);
            chk("st_addr", mem_addr, {a[31:2], 2'b00});
            chk("st_be", mem_be, exp_be);
            chk("st_wdata", mem_wdata, exp_wd);
            chk("st_stall", stall, (g == gnt_dly) ? 32'd0 : 32'd1);
            step();
        end
        mem_gnt = 0;
        idle_inputs();
        @(negedge clk);
        chk("st_after_req", mem_req, 0);
        chk("st_after_stall", stall, 0);
        step();
    endtask

    task automatic do_misaligned(input logic rd, input logic wr, input logic h, input logic [31:0] a);
        drive_op(rd, wr, h, 0, 0, a, 32'h12345678);
        @(negedge clk);
        chk("mis_pulse", misaligned, 1);
        chk("mis_stall", stall, 0);
        chk("mis_req", mem_req, 0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("mis_end", misaligned, 0);
        chk("mis_req_after", mem_req, 0);
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rvalid"}, rdata_valid, 0);
        chk({tag, "_mis"}, misaligned, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_be"}, mem_be, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0;
        #12;
        chk_all_zero("rst");
        step();
        reset = 1;
        step();

        // Byte loads
        do_load(32'h81, 0, 1, 0, 32'h1234FA78, 0, 0, 4'b0010, 32'hFFFFFFFA);
        do_load(32'h82, 0, 1, 0, 32'h1234FA78, 0, 0, 4'b0100, 32'h00000034);
        do_load(32'h81, 0, 1, 1, 32'h1234FA78, 0, 0, 4'b0010, 32'h000000FA);
        do_load(32'h80, 0, 1, 0, 32'h000000FA, 0, 0, 4'b0001, 32'hFFFFFFFA);
        do_load(32'h83, 0, 1, 0, 32'h1234FA78, 0, 0, 4'b1000, 32'h00000012);

        // Half loads
        do_load(32'h82, 1, 0, 1, 32'h8001ABCD, 0, 0, 4'b1100, 32'h00008001);
        do_load(32'h82, 1, 0, 0, 32'h8001ABCD, 0, 0, 4'b1100, 32'hFFFF8001);
        do_load(32'h80, 1, 0, 0, 32'h8001ABCD, 0, 0, 4'b0011, 32'hFFFFABCD);

        // Word load
        do_load(32'h84, 0, 0, 0, 32'hCAFEF00D, 1, 2, 4'b1111, 32'hCAFEF00D);

        // Stores with delayed grant
        do_store(32'h83, 0, 1, 32'hDEADBEEF, 3, 4'b1000, 32'hEFEFEFEF);
        do_store(32'h82, 1, 0, 32'hDEADBEEF, 3, 4'b1100, 32'hBEEFBEEF);
        do_store(32'h80, 0, 0, 32'hDEADBEEF, 3, 4'b1111, 32'hDEADBEEF);
        do_store(32'h81, 0, 1, 32'h000000A5, 0, 4'b0010, 32'hA5A5A5A5);

        // Misaligned accesses
        do_misaligned(1, 0, 1, 32'h81);
        do_misaligned(0, 1, 0, 32'h82);

        // Stray rvalid and gnt while idle must be ignored
        mem_rvalid = 1; mem_rdata = 32'h55555555; mem_gnt = 1;
        @(negedge clk);
        chk("stray_rv", rdata_valid, 0);
        chk("stray_req", mem_req, 0);
        chk("stray_stall", stall, 0);
        step();
        mem_rvalid = 0; mem_gnt = 0;

        // Slow memory
        do_load(32'h90, 0, 0, 0, 32'h0BADCAFE, 0, 5, 4'b1111, 32'h0BADCAFE);

        // Reset during WAIT_R abandons the access
        drive_op(1, 0, 0, 0, 0, 32'h100, 32'h0);
        step();
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        @(negedge clk);
        chk("rst_wait_stall", stall, 1);
        #2;
        reset = 0;
        idle_inputs();
        #1;
        chk_all_zero("midrst");
        step();
        reset = 1;
        mem_rvalid = 1; mem_rdata = 32'h77777777;
        @(negedge clk);
        chk("late_rv", rdata_valid, 0);
        chk("late_stall", stall, 0);
        step();
        mem_rvalid = 0;
        do_load(32'h104, 0, 0, 0, 32'h13579BDF, 0, 0, 4'b1111, 32'h13579BDF);

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
